// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM state encodings
// and the width of the stream length header.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } loader_state_e;

  localparam int HDR_W = 16;

endpackage

// File: rtl/word_packer.sv
// Byte-lane shift register that packs four bytes big-endian into a 32-bit
// word and presents it with a one-cycle valid on the cycle after byte 3.
module word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [1:0]  byte_cnt_o,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [23:0] lane_q, lane_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        vld_q, vld_d;
  logic [31:0] word_q, word_d;

  always_comb begin
    lane_d = lane_q;
    cnt_d  = cnt_q;
    vld_d  = 1'b0;
    word_d = word_q;
    if (clear_i) begin
      lane_d = '0;
      cnt_d  = '0;
    end else if (byte_valid_i) begin
      if (cnt_q == 2'd3) begin
        // Earliest byte sits at lane_q[23:16], so it lands in word[31:24].
        word_d = {lane_q, byte_i};
        vld_d  = 1'b1;
        cnt_d  = '0;
        lane_d = '0;
      end else begin
        lane_d = {lane_q[15:0], byte_i};
        cnt_d  = cnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= '0;
      cnt_q  <= '0;
      vld_q  <= 1'b0;
      word_q <= '0;
    end else begin
      lane_q <= lane_d;
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
      word_q <= word_d;
    end
  end

  assign byte_cnt_o   = cnt_q;
  assign word_valid_o = vld_q;
  assign word_o       = word_q;

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: byte stream -> instruction-memory words, holding
// the core in reset until done. LOADER_CHECKSUM_EN adds a trailing XOR check.
module prog_loader
  import loader_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        start,
  input  logic [7:0]  inByte,
  input  logic        inValid,
  output logic        inReady,
  output logic        memWriteEn,
  output logic [31:0] memAddr,
  output logic [31:0] memWriteData,
  output logic        coreRun,
  output logic        busy,
  output logic        error,
  output logic [2:0]  dbgState
);

  // Handshake: a byte transfers on a rising edge where inValid & inReady are
  // both high; inReady depends only on state, never on inValid.
  loader_state_e          state_q, state_d;
  logic [HDR_W-1:0]       len_q, len_d;
  logic [AW:0]            idx_q, idx_d;
  logic [AW:0]            wr_idx_q, wr_idx_d;
  logic                   accept;
  logic                   start_ok;
  logic                   pk_valid;
  logic [1:0]             pk_cnt;
  logic [31:0]            pk_word;
  logic [HDR_W-1:0]       len_full;
  logic [HDR_W-1:0]       idx_next;

`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_e ST_AFTER_DATA = ST_CHECK;
`else
  localparam loader_state_e ST_AFTER_DATA = ST_DONE;
`endif

  assign inReady  = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                    (state_q == ST_DATA)   || (state_q == ST_CHECK);
  assign busy     = inReady;
  assign error    = (state_q == ST_ERR);
  assign accept   = inValid & inReady;
  assign start_ok = start & ~busy;
  assign len_full = {len_q[HDR_W-1:8], inByte};
  assign idx_next = HDR_W'(idx_q) + 16'd1;
  assign dbgState = state_q;

  word_packer u_packer (
    .clk          (clk),
    .rst_n        (resetN),
    .clear_i      (start_ok),
    .byte_valid_i (accept && (state_q == ST_DATA)),
    .byte_i       (inByte),
    .byte_cnt_o   (pk_cnt),
    .word_valid_o (pk_valid),
    .word_o       (pk_word)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (start_ok) begin
      csum_d = '0;
    end else if (accept && (state_q != ST_CHECK)) begin
      csum_d = csum_q ^ inByte;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    wr_idx_d = wr_idx_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d = ST_LEN_HI;
          idx_d   = '0;
        end
      end
      ST_LEN_HI: begin
        if (accept) begin
          len_d   = {inByte, 8'h00};
          state_d = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (accept) begin
          len_d = len_full;
          if (len_full > HDR_W'(DEPTH)) begin
            state_d = ST_ERR;
          end else if (len_full == '0) begin
            state_d = ST_AFTER_DATA;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (accept && (pk_cnt == 2'd3)) begin
          // Address is captured with the word so both appear with the strobe.
          wr_idx_d = idx_q;
          idx_d    = idx_q + (AW+1)'(1);
          if (idx_next == len_q) begin
            state_d = ST_AFTER_DATA;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (accept) begin
          state_d = (inByte == csum_q) ? ST_DONE : ST_ERR;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      idx_q    <= '0;
      wr_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      wr_idx_q <= wr_idx_d;
    end
  end

  assign memWriteEn   = pk_valid;
  assign memWriteData = pk_word;
  assign memAddr      = {{(32-AW-3){1'b0}}, wr_idx_q, 2'b00};

  // DONE is entered together with the final write strobe; the core is only
  // released once that last write has landed.
  assign coreRun = (state_q == ST_DONE) && !pk_valid;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader (default build; the checksum
// cases are compiled in when LOADER_CHECKSUM_EN is defined).
module tb_prog_loader;

  logic        clk     = 1'b0;
  logic        resetN  = 1'b0;
  logic        start   = 1'b0;
  logic [7:0]  inByte  = 8'h00;
  logic        inValid = 1'b0;
  logic        inReady;
  logic        memWriteEn;
  logic [31:0] memAddr;
  logic [31:0] memWriteData;
  logic        coreRun;
  logic        busy;
  logic        error;
  logic [2:0]  dbgState;

  int total  = 0;
  int bad    = 0;
  int wr_cnt = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  stim[$];
  logic [7:0]  run_xor;

  always #5 clk = ~clk;

  prog_loader #(.DEPTH(256), .AW(8)) dut (
    .clk          (clk),
    .resetN       (resetN),
    .start        (start),
    .inByte       (inByte),
    .inValid      (inValid),
    .inReady      (inReady),
    .memWriteEn   (memWriteEn),
    .memAddr      (memAddr),
    .memWriteData (memWriteData),
    .coreRun      (coreRun),
    .busy         (busy),
    .error        (error),
    .dbgState     (dbgState)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: every observed write strobe is matched against exp_q.
  always @(negedge clk) begin
    if (resetN && memWriteEn) begin
      wr_cnt++;
      if (exp_q.size() > 0) chk("write", {memAddr, memWriteData}, exp_q.pop_front());
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    inByte  = b;
    inValid = 1'b1;
    while (!inReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!inReady) chk("ready_timeout", {63'd0, inReady}, 64'd1);
    @(negedge clk);
    inValid = 1'b0;
  endtask

  task automatic send_stream(input int gap);
    run_xor = 8'h00;
    foreach (stim[i]) begin
      send_byte(stim[i]);
      run_xor = run_xor ^ stim[i];
      if (gap > 0 && i != stim.size() - 1) repeat (gap) @(negedge clk);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Completes a load whose data bytes were just sent and checks the release.
  task automatic finish_ok(input string tag);
`ifdef LOADER_CHECKSUM_EN
    send_byte(run_xor);
`else
    chk({tag, "_we_last"}, {63'd0, memWriteEn}, 64'd1);
    chk({tag, "_run_during_wr"}, {63'd0, coreRun}, 64'd0);
    @(negedge clk);
`endif
    chk({tag, "_run"}, {63'd0, coreRun}, 64'd1);
    chk({tag, "_we_low"}, {63'd0, memWriteEn}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_err"}, {63'd0, error}, 64'd0);
    chk({tag, "_ready"}, {63'd0, inReady}, 64'd0);
  endtask

  task automatic push_n2();
    exp_q.push_back({32'h0000_0000, 32'h2008_0005});
    exp_q.push_back({32'h0000_0004, 32'h0109_5020});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", {63'd0, inReady}, 64'd0);
    chk("rst_we", {63'd0, memWriteEn}, 64'd0);
    chk("rst_run", {63'd0, coreRun}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_err", {63'd0, error}, 64'd0);
    chk("rst_bus", {memAddr, memWriteData}, 64'd0);
    resetN = 1'b1;
    @(negedge clk);

    // N = 2, back-to-back bytes
    wr_cnt = 0;
    push_n2();
    do_start();
    chk("t1_busy", {63'd0, busy}, 64'd1);
    stim = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
    send_stream(0);
    finish_ok("t1");
    chk("t1_wr_cnt", 64'(wr_cnt), 64'd2);

    // Same stream with inValid low on alternate cycles
    wr_cnt = 0;
    push_n2();
    do_start();
    send_stream(1);
    finish_ok("t2");
    repeat (3) @(negedge clk);
    chk("t2_wr_cnt", 64'(wr_cnt), 64'd2);
    chk("t2_q_empty", 64'(exp_q.size()), 64'd0);

    // Oversized header 0x0101 = 257
    wr_cnt = 0;
    do_start();
    stim = {8'h01, 8'h01};
    send_stream(0);
    chk("t3_err", {63'd0, error}, 64'd1);
    chk("t3_ready", {63'd0, inReady}, 64'd0);
    chk("t3_run", {63'd0, coreRun}, 64'd0);
    inByte  = 8'h55;
    inValid = 1'b1;
    repeat (3) @(negedge clk);
    inValid = 1'b0;
    chk("t3_err_held", {63'd0, error}, 64'd1);
    chk("t3_busy", {63'd0, busy}, 64'd0);
    chk("t3_wr_cnt", 64'(wr_cnt), 64'd0);

    // Reset after 6 data bytes, then a clean reload
    wr_cnt = 0;
    exp_q.push_back({32'h0000_0000, 32'h2008_0005});
    do_start();
    stim = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09};
    send_stream(0);
    chk("t4_busy_pre", {63'd0, busy}, 64'd1);
    resetN = 1'b0;
    #1;
    chk("t4_ready", {63'd0, inReady}, 64'd0);
    chk("t4_we", {63'd0, memWriteEn}, 64'd0);
    chk("t4_run_busy_err", {61'd0, coreRun, busy, error}, 64'd0);
    chk("t4_bus", {memAddr, memWriteData}, 64'd0);
    chk("t4_state", 64'(dbgState), 64'd0);
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    chk("t4_wr_partial", 64'(wr_cnt), 64'd1);
    wr_cnt = 0;
    push_n2();
    do_start();
    stim = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
    send_stream(0);
    finish_ok("t4");
    chk("t4_wr_cnt", 64'(wr_cnt), 64'd2);

    // N = 0, then a restart from DONE
    wr_cnt = 0;
    do_start();
    stim = {8'h00, 8'h00};
    send_stream(0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(run_xor);
`endif
    chk("t5_run", {63'd0, coreRun}, 64'd1);
    chk("t5_busy", {63'd0, busy}, 64'd0);
    do_start();
    chk("t5_run_drop", {63'd0, coreRun}, 64'd0);
    chk("t5_busy_restart", {63'd0, busy}, 64'd1);
    chk("t5_ready_restart", {63'd0, inReady}, 64'd1);
    chk("t5_wr_cnt", 64'(wr_cnt), 64'd0);

`ifdef LOADER_CHECKSUM_EN
    // Still in LEN_HI from the restart above
    wr_cnt = 0;
    exp_q.push_back({32'h0000_0000, 32'hAABB_CCDD});
    stim = {8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_stream(0);
    send_byte(8'h01);
    chk("c1_run", {63'd0, coreRun}, 64'd1);
    chk("c1_err", {63'd0, error}, 64'd0);
    exp_q.push_back({32'h0000_0000, 32'hAABB_CCDD});
    do_start();
    send_stream(0);
    send_byte(8'h00);
    chk("c2_err", {63'd0, error}, 64'd1);
    chk("c2_run", {63'd0, coreRun}, 64'd0);
    chk("c_wr_cnt", 64'(wr_cnt), 64'd2);
`endif

    repeat (2) @(negedge clk);
    chk("final_q_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
